// File: rtl/sum_alarm_monitor_pkg.sv
// Shared types and defaults for the window-sum alarm monitor.
package sum_alarm_monitor_pkg;

   localparam int unsigned SUM_W = 10;
   localparam int unsigned AVG_W = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned ACNT_W = 8;

   localparam int unsigned DEF_HI_THR = 800;
   localparam int unsigned DEF_LO_THR = 600;
   localparam int unsigned DEF_HOLD   = 3;

   // Encodings are visible on the state output, so they are fixed explicitly.
   typedef enum logic [1:0] {
      StNormal  = 2'b00,
      StPend    = 2'b01,
      StAlarm   = 2'b10,
      StRelease = 2'b11
   } mon_state_t;

endpackage

// File: rtl/sum_alarm_monitor_peak_hold.sv
// Running maximum of sampled sums; clear restarts it from the current sample.
module sum_alarm_monitor_peak_hold
   import sum_alarm_monitor_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             clear,
   input  logic [SUM_W-1:0] sum_in,
   output logic [SUM_W-1:0] peak
);

   logic [SUM_W-1:0] peak_q;

   // Peak register: clear seeds with this edge's sample (or zero when idle).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_q <= '0;
      end else if (clear) begin
         peak_q <= sample_en ? sum_in : '0;
      end else if (sample_en && (sum_in > peak_q)) begin
         peak_q <= sum_in;
      end
   end

   assign peak = peak_q;

endmodule

// File: rtl/sum_alarm_monitor.sv
// Window-sum consumer: registered average, peak, persistence alarm FSM and
// alarm episode counter.
module sum_alarm_monitor
   import sum_alarm_monitor_pkg::*;
#(
   parameter int unsigned HI_THR = DEF_HI_THR,
   parameter int unsigned LO_THR = DEF_LO_THR,
   parameter int unsigned HOLD   = DEF_HOLD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SUM_W-1:0]  sum_in,
   input  logic              sample_en,
   input  logic              clear,
   output logic [AVG_W-1:0]  avg,
   output logic [SUM_W-1:0]  peak,
   output logic              alarm,
   output logic [1:0]        state,
   output logic [ACNT_W-1:0] alarm_count
);

   if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
      $error("sum_alarm_monitor: HOLD must be in 1..15");
   end
   if (LO_THR > HI_THR) begin : g_bad_thr
      $error("sum_alarm_monitor: LO_THR must not exceed HI_THR");
   end

   localparam logic [SUM_W-1:0] HiThr    = SUM_W'(HI_THR);
   localparam logic [SUM_W-1:0] LoThr    = SUM_W'(LO_THR);
   localparam logic [CNT_W-1:0] HoldCnt  = CNT_W'(HOLD);
   localparam bit               HoldOne  = (HOLD == 1);

   mon_state_t        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              alarm_q;
   logic [AVG_W-1:0]  avg_q;
   logic [ACNT_W-1:0] alarm_count_q;

   logic             is_high;
   logic             is_low;
   logic [CNT_W-1:0] cnt_inc;
   logic             enter_alarm;

   // Sample qualification and detection of a fresh alarm episode.
   always_comb begin
      is_high     = (sum_in >= HiThr);
      is_low      = (sum_in < LoThr);
      cnt_inc     = cnt_q + 4'd1;
      enter_alarm = sample_en && is_high &&
                    (((state_q == StNormal) && HoldOne) ||
                     ((state_q == StPend) && (cnt_inc == HoldCnt)));
   end

   // Persistence FSM with registered alarm flag; moves only on sampled edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StNormal;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
      end else if (sample_en) begin
         unique case (state_q)
            StNormal: begin
               if (is_high) begin
                  if (HoldOne) begin
                     state_q <= StAlarm;
                     alarm_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= StPend;
                     cnt_q   <= 4'd1;
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
            StPend: begin
               if (!is_high) begin
                  state_q <= StNormal;
                  cnt_q   <= '0;
               end else if (cnt_inc == HoldCnt) begin
                  state_q <= StAlarm;
                  alarm_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StAlarm: begin
               if (is_low) begin
                  if (HoldOne) begin
                     state_q <= StNormal;
                     alarm_q <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= StRelease;
                     cnt_q   <= 4'd1;
                  end
               end
            end
            StRelease: begin
               // Bouncing back to ALARM is the same episode, not a new one.
               if (!is_low) begin
                  state_q <= StAlarm;
                  cnt_q   <= '0;
               end else if (cnt_inc == HoldCnt) begin
                  state_q <= StNormal;
                  alarm_q <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= StNormal;
               alarm_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Average register: floor(sum/4) of the latest sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avg_q <= '0;
      end else if (sample_en) begin
         avg_q <= sum_in[SUM_W-1:2];
      end
   end

   // Episode counter: saturating; clear still counts an entry on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_count_q <= '0;
      end else if (clear) begin
         alarm_count_q <= enter_alarm ? 8'd1 : 8'd0;
      end else if (enter_alarm && (alarm_count_q != 8'hFF)) begin
         alarm_count_q <= alarm_count_q + 8'd1;
      end
   end

   sum_alarm_monitor_peak_hold u_peak_hold (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .clear     (clear),
      .sum_in    (sum_in),
      .peak      (peak)
   );

   assign avg         = avg_q;
   assign alarm       = alarm_q;
   assign state       = state_q;
   assign alarm_count = alarm_count_q;

endmodule

// File: tb/tb_sum_alarm_monitor.sv
// Self-checking bench for sum_alarm_monitor against a run-length reference model.
module tb_sum_alarm_monitor;

   localparam int HI = 800;
   localparam int LO = 600;
   localparam int HOLD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] sum_in = '0;
   logic       sample_en = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] avg;
   logic [9:0] peak;
   logic       alarm;
   logic [1:0] state;
   logic [7:0] alarm_count;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: alarm flag plus length of the current qualifying run.
   int m_avg, m_peak, m_count, m_run;
   bit m_alarm;

   sum_alarm_monitor #(
      .HI_THR (HI),
      .LO_THR (LO),
      .HOLD   (HOLD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sum_in      (sum_in),
      .sample_en   (sample_en),
      .clear       (clear),
      .avg         (avg),
      .peak        (peak),
      .alarm       (alarm),
      .state       (state),
      .alarm_count (alarm_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_avg = 0; m_peak = 0; m_count = 0; m_run = 0; m_alarm = 0;
   endtask

   function automatic int model_state();
      if (!m_alarm) return (m_run == 0) ? 0 : 1;
      return (m_run == 0) ? 2 : 3;
   endfunction

   task automatic model_step(input int s, input bit en, input bit clr);
      bit entered = 0;
      if (en) begin
         m_avg = s / 4;
         if (s > m_peak) m_peak = s;
         if (!m_alarm) begin
            if (s >= HI) begin
               m_run++;
               if (m_run == HOLD) begin
                  m_alarm = 1; m_run = 0; entered = 1;
                  if (m_count < 255) m_count++;
               end
            end else m_run = 0;
         end else begin
            if (s < LO) begin
               m_run++;
               if (m_run == HOLD) begin m_alarm = 0; m_run = 0; end
            end else m_run = 0;
         end
      end
      if (clr) begin
         m_peak  = en ? s : 0;
         m_count = entered ? 1 : 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".avg"},   32'(avg),         32'(m_avg));
      check({tag, ".peak"},  32'(peak),        32'(m_peak));
      check({tag, ".alarm"}, 32'(alarm),       32'(m_alarm));
      check({tag, ".state"}, 32'(state),       32'(model_state()));
      check({tag, ".count"}, 32'(alarm_count), 32'(m_count));
   endtask

   // Drive one edge's inputs, update the model at the edge, compare after it.
   task automatic cyc(input string tag, input int s, input bit en, input bit clr);
      sum_in = 10'(s); sample_en = en; clear = clr;
      @(posedge clk);
      model_step(s, en, clr);
      #1;
      check_all(tag);
   endtask

   function automatic int pick(input int cat);
      int b[4] = '{599, 600, 799, 800};
      case (cat)
         0: return $urandom_range(800, 1020);
         1: return $urandom_range(0, 599);
         2: return $urandom_range(600, 799);
         default: return b[$urandom_range(0, 3)];
      endcase
   endfunction

   initial begin
      int cat, left;
      model_reset();
      #3;
      check_all("reset");

      @(negedge clk);
      reset = 1'b0;

      // Entry after three highs.
      cyc("p2a", 900, 1, 0); check("p2a.st", 32'(state), 1);
      cyc("p2b", 900, 1, 0); check("p2b.st", 32'(state), 1);
      cyc("p2c", 900, 1, 0); check("p2c.st", 32'(state), 2);
      check("p2.alarm", 32'(alarm), 1);
      check("p2.count", 32'(alarm_count), 1);
      check("p2.avg", 32'(avg), 225);

      // Release with a bounce on 600 (not low).
      cyc("p4a", 500, 1, 0); check("p4a.st", 32'(state), 3);
      cyc("p4b", 500, 1, 0);
      cyc("p4c", 600, 1, 0); check("p4c.st", 32'(state), 2);
      cyc("p4d", 599, 1, 0);
      cyc("p4e", 599, 1, 0); check("p4e.alarm", 32'(alarm), 1);
      cyc("p4f", 599, 1, 0); check("p4f.st", 32'(state), 0);
      check("p4f.alarm", 32'(alarm), 0);

      // 800 is high, 799 is not.
      cyc("p3a", 800, 1, 0);
      cyc("p3b", 800, 1, 0);
      cyc("p3c", 799, 1, 0); check("p3c.st", 32'(state), 0);
      cyc("p3d", 800, 1, 0); check("p3d.st", 32'(state), 1);
      cyc("p3e", 500, 1, 0);

      // Idle edges change nothing; clear reseeds peak and count.
      for (int i = 0; i < 5; i++) cyc("p5idle", 1020, 0, 0);
      cyc("p5clr", 300, 1, 1);
      check("p5.peak", 32'(peak), 300);
      check("p5.count", 32'(alarm_count), 0);
      check("p5.avg", 32'(avg), 75);

      // Clear on the very edge that enters alarm counts that entry.
      cyc("p5h1", 900, 1, 0);
      cyc("p5h2", 900, 1, 0);
      cyc("p5h3", 850, 1, 1);
      check("p5h3.count", 32'(alarm_count), 1);

      // Randomized streaks with occasional idle edges and clears.
      cat = 0; left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            cat  = $urandom_range(0, 3);
            left = $urandom_range(1, 6);
         end
         left--;
         cyc("rand", pick(cat), ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0));
      end

      // Saturation: settle to NORMAL, clear, then 256 episodes.
      for (int i = 0; i < 3; i++) cyc("sat_settle", 100, 1, 0);
      cyc("sat_clr", 100, 1, 1);
      for (int e = 0; e < 256; e++) begin
         for (int i = 0; i < 3; i++) cyc("sat_hi", 900, 1, 0);
         for (int i = 0; i < 3; i++) cyc("sat_lo", 100, 1, 0);
      end
      check("sat.count", 32'(alarm_count), 255);

      // Asynchronous reset in the middle of PEND.
      cyc("pend", 900, 1, 0);
      check("pend.st", 32'(state), 1);
      reset = 1'b1;
      #2;
      model_reset();
      check_all("areset");
      @(negedge clk);
      reset = 1'b0;
      cyc("post", 400, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
